// File: rtl/puzzle_fill_ctrl.sv
// puzzle_fill_ctrl
//   Fills the 3x3 puzzle board with a random permutation of 1..9, one value
//   per accepted LFSR draw, and serves a registered row read port to the
//   7-segment display scanner.
//
// Ports
//   clk       system clock
//   clr       asynchronous active-low reset
//   start     fill request (level; rising edge starts a fill from IDLE/DONE)
//   row_sel   row to read: 0=row1, 1=row2, 2=row3, 3=blank
//   row_data  registered selected row: [11:8] left, [7:4] middle, [3:0] right
//   busy      fill in progress
//   done      board complete
//   fill_cnt  cells placed so far, 0..9
module puzzle_fill_ctrl #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  row_sel,
  output logic [11:0] row_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  fill_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  TRY_LIM = 8'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_nx;
  logic        start_q, start_rise;
  logic [3:0]  cell_q [9];
  logic [8:0]  used_q;
  logic [15:0] used_ext;
  logic [7:0]  retry_q, retry_d;
  logic [3:0]  cand, free_idx, place_idx;
  logic        cand_ok, clear, place;
  logic [11:0] row1, row2, row3, row_mux;

  assign start_rise = start & ~start_q;
  assign cand       = lfsr_q[3:0];
  assign used_ext   = {7'b0, used_q};
  assign cand_ok    = (cand < 4'd9) && !used_ext[cand];
  assign lfsr_nx    = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400)
                                : {1'b0, lfsr_q[15:1]};

  assign row1 = {cell_q[0], cell_q[1], cell_q[2]};
  assign row2 = {cell_q[3], cell_q[4], cell_q[5]};
  assign row3 = {cell_q[6], cell_q[7], cell_q[8]};

  // Lowest-index free cell: scanning from the top lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!used_q[8 - i]) free_idx = 4'(8 - i);
    end
  end

  always_comb begin
    case (row_sel)
      2'd0:    row_mux = row1;
      2'd1:    row_mux = row2;
      2'd2:    row_mux = row3;
      default: row_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    clear     = 1'b0;
    place     = 1'b0;
    place_idx = cand;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          clear   = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        busy = 1'b1;
        if (cand_ok) begin
          place   = 1'b1;
          retry_d = '0;
        end else if (retry_q != TRY_LIM) begin
          retry_d = retry_q + 8'd1;
        end else begin
          place     = 1'b1;
          place_idx = free_idx;
          retry_d   = '0;
        end
        if (place && fill_cnt == 4'd8) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start_rise) begin
          clear   = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) retry_d = '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      lfsr_q   <= SEED_NZ;
      start_q  <= 1'b0;
      retry_q  <= '0;
      used_q   <= '0;
      fill_cnt <= '0;
      row_data <= '0;
      for (int unsigned i = 0; i < 9; i++) cell_q[i] <= '0;
    end else begin
      lfsr_q   <= lfsr_nx;
      start_q  <= start;
      retry_q  <= retry_d;
      row_data <= row_mux;
      if (clear) begin
        used_q   <= '0;
        fill_cnt <= '0;
        for (int unsigned i = 0; i < 9; i++) cell_q[i] <= '0;
      end else if (place) begin
        // Next value to place is always fill_cnt + 1.
        for (int unsigned i = 0; i < 9; i++) begin
          if (place_idx == 4'(i)) begin
            cell_q[i] <= fill_cnt + 4'd1;
            used_q[i] <= 1'b1;
          end
        end
        fill_cnt <= fill_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_puzzle_fill_ctrl.sv
module tb_puzzle_fill_ctrl;

  localparam logic [15:0] SEED1 = 16'hACE1;
  localparam logic [15:0] SEED2 = 16'h001E;  // first draw gives candidate 15

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, start;
  logic [1:0]  row_sel;
  logic [11:0] row_data;
  logic        busy, done;
  logic [3:0]  fill_cnt;

  logic        clr2, start2;
  logic [1:0]  row_sel2;
  logic [11:0] row_data2;
  logic        busy2, done2;
  logic [3:0]  fill_cnt2;

  puzzle_fill_ctrl #(.SEED(SEED1), .MAX_TRIES(15)) dut (
    .clk(clk), .clr(clr), .start(start), .row_sel(row_sel),
    .row_data(row_data), .busy(busy), .done(done), .fill_cnt(fill_cnt)
  );

  puzzle_fill_ctrl #(.SEED(SEED2), .MAX_TRIES(0)) dut0 (
    .clk(clk), .clr(clr2), .start(start2), .row_sel(row_sel2),
    .row_data(row_data2), .busy(busy2), .done(done2), .fill_cnt(fill_cnt2)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference LFSR, running in lockstep with the main DUT since reset.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge clr) begin
    if (!clr) m_lfsr <= SEED1;
    else      m_lfsr <= lstep(m_lfsr);
  end

  // Reference fill: board, fill count after each FILL cycle, total cycles.
  logic [3:0] pb [9];
  int         pcnt [0:255];
  int         pcyc;

  task automatic predict(input logic [15:0] l0, input int maxt);
    logic [15:0] l;
    bit used [9];
    int n, tries, c;
    bit found;
    l = l0; n = 0; tries = 0; pcyc = 0; pcnt[0] = 0;
    for (int k = 0; k < 9; k++) begin used[k] = 0; pb[k] = 4'd0; end
    while (n < 9 && pcyc < 200) begin
      l = lstep(l);
      pcyc++;
      c = int'(l[3:0]);
      if (c < 9 && !used[c]) begin
        used[c] = 1; pb[c] = 4'(n + 1); n++; tries = 0;
      end else if (tries < maxt) begin
        tries++;
      end else begin
        found = 0;
        for (int k = 0; k < 9; k++) begin
          if (!found && !used[k]) begin
            used[k] = 1; pb[k] = 4'(n + 1); found = 1;
          end
        end
        n++; tries = 0;
      end
      pcnt[pcyc] = n;
    end
  endtask

  function automatic bit is_perm(input logic [11:0] a, input logic [11:0] b,
                                 input logic [11:0] c);
    logic [35:0] all;
    int seen [10];
    int v;
    all = {a, b, c};
    for (int k = 0; k < 10; k++) seen[k] = 0;
    for (int k = 0; k < 9; k++) begin
      v = int'(all[k*4 +: 4]);
      if (v < 1 || v > 9) return 0;
      seen[v]++;
    end
    for (int k = 1; k < 10; k++) if (seen[k] != 1) return 0;
    return 1;
  endfunction

  logic [11:0] rd  [4];
  logic [11:0] rd2 [4];
  logic [11:0] saved [3];

  task automatic read_rows();
    for (int s = 0; s < 4; s++) begin
      row_sel = 2'(s);
      @(negedge clk);
      rd[s] = row_data;
    end
  endtask

  task automatic read_rows2();
    for (int s = 0; s < 4; s++) begin
      row_sel2 = 2'(s);
      @(negedge clk);
      rd2[s] = row_data2;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    clr   = 1'b1;
  endtask

  // Starts a fill at the current negedge and follows it cycle by cycle.
  task automatic run_fill(input string tag, input bit toggle);
    logic [11:0] exp_row;
    predict(m_lfsr, 15);
    start = 1'b1;
    @(negedge clk);
    if (!toggle) start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || fill_cnt !== 4'd0) begin
      bad++;
      $display("FAIL %s_enter: busy=%b done=%b cnt=%0d want busy=1 done=0 cnt=0",
               tag, busy, done, fill_cnt);
    end
    for (int j = 1; j <= pcyc; j++) begin
      if (toggle && (j % 3 == 0)) start = ~start;
      @(negedge clk);
      total++;
      if (fill_cnt !== 4'(pcnt[j]) || busy !== (j < pcyc) || done !== (j == pcyc)) begin
        bad++;
        $display("FAIL %s_cyc%0d: cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 tag, j, fill_cnt, busy, done, pcnt[j], (j < pcyc), (j == pcyc));
      end
    end
    start = 1'b0;
    read_rows();
    for (int r = 0; r < 3; r++) begin
      exp_row = {pb[3*r], pb[3*r+1], pb[3*r+2]};
      total++;
      if (rd[r] !== exp_row) begin
        bad++;
        $display("FAIL %s_row%0d: got %h want %h", tag, r, rd[r], exp_row);
      end
    end
    total++;
    if (rd[3] !== 12'h000) begin
      bad++;
      $display("FAIL %s_blank: got %h want 000", tag, rd[3]);
    end
    total++;
    if (!is_perm(rd[0], rd[1], rd[2])) begin
      bad++;
      $display("FAIL %s_perm: rows %h %h %h not a permutation of 1..9",
               tag, rd[0], rd[1], rd[2]);
    end
    total++;
    if (fill_cnt !== 4'd9 || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL %s_final: cnt=%0d busy=%b done=%b want cnt=9 busy=0 done=1",
               tag, fill_cnt, busy, done);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    #2 clr = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fill_cnt !== 4'd0 || row_data !== 12'h000) begin
      bad++;
      $display("FAIL reset_async: busy=%b done=%b cnt=%0d row=%h want all 0",
               busy, done, fill_cnt, row_data);
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fill_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b done=%b cnt=%0d want all 0",
               busy, done, fill_cnt);
    end
    read_rows();
    for (int s = 0; s < 4; s++) begin
      total++;
      if (rd[s] !== 12'h000) begin
        bad++;
        $display("FAIL reset_row%0d: got %h want 000", s, rd[s]);
      end
    end
  endtask

  task automatic test_fill();
    apply_reset();
    repeat (10) @(negedge clk);
    run_fill("fill_c10", 1'b0);
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      run_fill("fill_rand", 1'b0);
    end
    apply_reset();
    repeat ($urandom_range(1, 60)) @(negedge clk);
    run_fill("fill_idle_rand", 1'b0);
  endtask

  task automatic test_ignore_start();
    apply_reset();
    repeat ($urandom_range(2, 20)) @(negedge clk);
    run_fill("ignore_start", 1'b1);
  endtask

  task automatic test_midreset();
    int k;
    apply_reset();
    repeat ($urandom_range(1, 15)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (fill_cnt !== 4'd4 && k < 300) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (fill_cnt !== 4'd4) begin
      bad++;
      $display("FAIL midrst_reach4: cnt=%0d want 4 within 300 cycles", fill_cnt);
    end
    #2 clr = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fill_cnt !== 4'd0 || row_data !== 12'h000) begin
      bad++;
      $display("FAIL midrst_async: busy=%b done=%b cnt=%0d row=%h want all 0",
               busy, done, fill_cnt, row_data);
    end
    @(negedge clk);
    clr = 1'b1;
    read_rows();
    for (int s = 0; s < 4; s++) begin
      total++;
      if (rd[s] !== 12'h000) begin
        bad++;
        $display("FAIL midrst_row%0d: got %h want 000", s, rd[s]);
      end
    end
    run_fill("midrst_refill", 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    repeat (20) @(negedge clk);
    run_fill("rep_a", 1'b0);
    for (int r = 0; r < 3; r++) saved[r] = rd[r];
    apply_reset();
    repeat (20) @(negedge clk);
    run_fill("rep_b", 1'b0);
    for (int r = 0; r < 3; r++) begin
      total++;
      if (rd[r] !== saved[r]) begin
        bad++;
        $display("FAIL repeat_row%0d: got %h want %h", r, rd[r], saved[r]);
      end
    end
    run_fill("rep_done_refill", 1'b0);
    total++;
    if (rd[0] === saved[0] && rd[1] === saved[1] && rd[2] === saved[2]) begin
      bad++;
      $display("FAIL refill_differs: got %h %h %h want a different board",
               rd[0], rd[1], rd[2]);
    end
  endtask

  task automatic test_max_tries0();
    logic [11:0] exp_row;
    predict(SEED2, 0);
    start2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b1;  // start held high through release counts as an edge
    @(negedge clk);
    total++;
    if (busy2 !== 1'b1 || fill_cnt2 !== 4'd0) begin
      bad++;
      $display("FAIL mt0_enter: busy=%b cnt=%0d want busy=1 cnt=0", busy2, fill_cnt2);
    end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      total++;
      if (done2 !== (j == 9) || fill_cnt2 !== 4'(j)) begin
        bad++;
        $display("FAIL mt0_cyc%0d: done=%b cnt=%0d want done=%b cnt=%0d",
                 j, done2, fill_cnt2, (j == 9), j);
      end
    end
    start2 = 1'b0;
    read_rows2();
    total++;
    if (rd2[0][11:8] !== 4'd1) begin
      bad++;
      $display("FAIL mt0_cell0: got %0d want 1", rd2[0][11:8]);
    end
    for (int r = 0; r < 3; r++) begin
      exp_row = {pb[3*r], pb[3*r+1], pb[3*r+2]};
      total++;
      if (rd2[r] !== exp_row) begin
        bad++;
        $display("FAIL mt0_row%0d: got %h want %h", r, rd2[r], exp_row);
      end
    end
    total++;
    if (!is_perm(rd2[0], rd2[1], rd2[2])) begin
      bad++;
      $display("FAIL mt0_perm: rows %h %h %h", rd2[0], rd2[1], rd2[2]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; start = 1'b0; row_sel = 2'd0;
    clr2 = 1'b1; start2 = 1'b0; row_sel2 = 2'd0;
    #1 clr2 = 1'b0;
    test_reset();
    test_fill();
    test_ignore_start();
    test_midreset();
    test_back_to_back();
    test_max_tries0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puzzle_fill_ctrl.md
Name: puzzle_fill_ctrl

Overview:
- Sequencer that fills the 3x3 puzzle board with a random permutation of values 1..9, placing one value per accepted random draw.
- Sits between the push-button front end and the 7-segment row display.
- Owns the board registers (row1/row2/row3) and the used-cell mask.
- Also serves a registered row read port to the display scanner.

Parameters:
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- MAX_TRIES, 15: consecutive rejected draws allowed before deterministic fallback placement. Range 0..255.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous, active-low reset
- start  in  1  fill request, level input, rising-edge detected internally
- row_sel  in  2  row to read: 0=row1, 1=row2, 2=row3, 3=blank
- row_data  out  12  selected row, registered: [11:8] left cell, [7:4] middle, [3:0] right
- busy  out  1  fill in progress
- done  out  1  board complete, all 9 cells hold distinct values 1..9
- fill_cnt  out  4  cells placed so far, 0..9

Behaviour:
- Reset (clr=0, asynchronous):
  - row1/row2/row3 = 0; used mask = 0; next value = 1; retry count = 0.
  - LFSR = SEED; state = IDLE.
  - row_data = 0, busy = 0, done = 0, fill_cnt = 0.
  - Start edge-detect register is cleared to 0, so a start held high through reset release counts as a rising edge.
- LFSR:
  - 16-bit Galois, polynomial 0xB400 (x^16+x^14+x^13+x^11+1).
  - Advances every cycle in every state after reset, never zero.
  - Candidate cell each cycle = lfsr[3:0].
- Cell mapping: cell k sits in row k/3; nibble [11:8], [7:4], [3:0] for k%3 = 0, 1, 2 respectively. Unfilled cells read 0.
- State IDLE:
  - busy = 0, done = 0.
  - Start rising edge: clear board, mask, fill_cnt, retry count; next value = 1; go to FILL.
- State FILL:
  - busy = 1; one decision per cycle.
  - Candidate accepted if candidate < 9 and used[candidate] = 0.
    - Write the next value to that cell, set its used bit, increment value and fill_cnt, clear retry count.
  - Candidate rejected:
    - If retry count < MAX_TRIES: increment retry count, write nothing.
    - If retry count = MAX_TRIES: place the value in the lowest-index free cell, clear retry count.
  - Transition to DONE in the cycle after the 9th placement (fill_cnt = 9).
  - Worst-case fill latency: 9*(MAX_TRIES+1) cycles after the start edge.
- State DONE:
  - busy = 0, done = 1; board held stable.
  - Start rising edge: clear and refill exactly as from IDLE; done drops in the next cycle.
- Start edges while in FILL are ignored; no restart.
- Read port:
  - row_data updates on every clock from row_sel with 1-cycle latency, in any state.
  - row_sel = 3 returns 12'h000.
  - A cell written in cycle N is visible on row_data in cycle N+1 if selected.
- A value is never written twice; a used cell is never overwritten within one fill.
- Reset asserted mid-fill aborts immediately; all outputs return to reset values.
- Same reset release and same start cycle yield an identical board (deterministic, repeatable).

Test Plan:
- Reset, no start for 100 cycles -> busy=0, done=0, fill_cnt=0, row_data=12'h000 for row_sel 0..3.
- Start pulse at cycle 10 after reset release, default parameters -> done=1 within 144 cycles. The 9 nibbles read via row_sel 0,1,2 are a permutation of 1..9. fill_cnt=9. busy=0 after done.
- MAX_TRIES=0 and SEED forcing an early candidate of 9..15 -> that cycle places into the lowest free cell (cell 0 on the first draw holds 1). Total fill completes in exactly 9 cycles.
- Start toggled every 3 cycles during FILL -> no restart. fill_cnt stays monotonic up to 9. Final board is still a valid permutation.
- clr pulsed low while fill_cnt=4 -> all outputs 0 asynchronously, board reads 12'h000. A fresh start then completes a valid fill.
- Two runs with identical reset release and start at cycle 20 -> bit-identical row1/row2/row3. A start in DONE refills and produces a different board, with done low for at least 9 cycles.
